// File: rtl/spike_train_encoder.sv
// Sigma-delta rate encoder: turns LANES signed activations into T_STEPS spike/polarity timesteps per sample.
// Latency: sample accepted at edge k, first timestep registered at the next edge that sees step_en=1.
// Backpressure: in_ready only while IDLE; step_en=0 stalls the train with residuals and counter held.
module spike_train_encoder #(
    parameter int LANES      = 4,
    parameter int DATA_W     = 16,
    parameter int T_STEPS    = 16,
    parameter int FULL_SCALE = 4096,
    parameter int STEP_W     = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      step_en,
    output logic                      out_valid,
    output logic [LANES-1:0]          out_spike,
    output logic [LANES-1:0]          out_polarity,
    output logic [STEP_W-1:0]         step_idx,
    output logic                      out_last,
    output logic                      busy
);

    localparam logic [DATA_W-1:0] FS        = DATA_W'(FULL_SCALE);
    localparam logic [DATA_W-1:0] HALF_FS   = DATA_W'(FULL_SCALE / 2);
    localparam logic [DATA_W-1:0] ABS_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mag [LANES];
    logic [DATA_W-1:0]   r_res [LANES];
    logic [LANES-1:0]    r_sign;
    logic [STEP_W-1:0]   r_cnt;

    logic [DATA_W-1:0]   w_mag_in [LANES];
    logic [LANES-1:0]    w_sign_in;
    logic [DATA_W:0]     w_t [LANES];
    logic [DATA_W-1:0]   w_res_nxt [LANES];
    logic [LANES-1:0]    w_spk;

    logic                w_accept;
    logic                w_step;
    logic                w_final;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_step   = step_en && (r_state == ST_RUN);
    assign w_final  = (r_cnt == LAST_STEP);
    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);

    // Per-lane magnitude capture: saturate the most negative code, then clamp to full scale.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic [DATA_W-1:0] raw;
            logic [DATA_W-1:0] absval;
            raw          = in_data[i*DATA_W +: DATA_W];
            w_sign_in[i] = raw[DATA_W-1];
            if (!raw[DATA_W-1])
                absval = raw;
            else if (raw == MOST_NEG)
                absval = ABS_MAX;
            else
                absval = ~raw + 1'b1;
            w_mag_in[i] = (absval > FS) ? FS : absval;
        end
    end

    // Sigma-delta step: add magnitude to residual, fire and subtract full scale on overflow.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_t[i]       = {1'b0, r_res[i]} + {1'b0, r_mag[i]};
            w_spk[i]     = (w_t[i] >= {1'b0, FS});
            w_res_nxt[i] = w_spk[i] ? DATA_W'(w_t[i] - {1'b0, FS}) : w_t[i][DATA_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state: accept in IDLE, return to IDLE after the final emitted timestep.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_step && w_final) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latched sample and encoder residuals; residuals restart at half scale for rounding.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LANES; i++) begin
                r_mag[i] <= '0;
                r_res[i] <= '0;
            end
            r_sign <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < LANES; i++) begin
                r_mag[i] <= w_mag_in[i];
                r_res[i] <= HALF_FS;
            end
            r_sign <= w_sign_in;
            r_cnt  <= '0;
        end else if (w_step) begin
            for (int i = 0; i < LANES; i++)
                r_res[i] <= w_res_nxt[i];
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered outputs: spikes only with a valid step, polarity and index hold across stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid    <= 1'b0;
            out_spike    <= '0;
            out_polarity <= '1;
            step_idx     <= '0;
            out_last     <= 1'b0;
        end else begin
            out_valid <= w_step;
            out_spike <= w_step ? w_spk : '0;
            out_last  <= w_step && w_final;
            if (w_step) begin
                out_polarity <= ~r_sign;
                step_idx     <= r_cnt;
            end
        end
    end

endmodule
